rvh_pmp_check_arb: RTL and testbench

RVH_PMP_CHECK_ARB -- requirements
Module: rvh_pmp_check_arb

---
 rtl/rvh_pmp_pkg.sv | 24 ++
 rtl/rvh_pmp_dffre.sv | 20 ++
 rtl/rvh_pmp_rr_arb.sv | 47 ++++
 rtl/rvh_pmp_check_arb.sv | 115 +++++++++++
 tb/tb_rvh_pmp_check_arb.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/rvh_pmp_pkg.sv
// Shared PMP encodings: access types, pmpcfg.A address-matching modes, and
// the helper that sizes requester index fields.
package rvh_pmp_pkg;

  typedef enum logic [1:0] {
    PMP_ACC_R    = 2'd0,
    PMP_ACC_W    = 2'd1,
    PMP_ACC_X    = 2'd2,
    PMP_ACC_RSVD = 2'd3
  } pmp_access_e;

  typedef enum logic [1:0] {
    PMPCFG_A_OFF   = 2'd0,
    PMPCFG_A_TOR   = 2'd1,
    PMPCFG_A_NA4   = 2'd2,
    PMPCFG_A_NAPOT = 2'd3
  } pmpcfg_a_e;

  // A single requester still needs a one-bit index field.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rvh_pmp_dffre.sv
// Flip-flop with asynchronous active-low reset to zero and a load enable.
module rvh_pmp_dffre #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/rvh_pmp_rr_arb.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves
// one past the winner whenever a grant is issued.
module rvh_pmp_rr_arb
  import rvh_pmp_pkg::*;
#(
  parameter int unsigned REQ_NUM = 3,
  parameter int unsigned ID_W    = id_width(REQ_NUM)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [REQ_NUM-1:0] req_i,
  input  logic               en_i,
  output logic [REQ_NUM-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;
  logic            adv;
  int unsigned     idx;

  always_comb begin
    found     = 1'b0;
    gnt_idx_o = '0;
    idx       = 0;
    for (int unsigned off = 0; off < REQ_NUM; off++) begin
      idx = (32'(ptr_q) + off) % REQ_NUM;
      if (!found && req_i[idx]) begin
        found     = 1'b1;
        gnt_idx_o = ID_W'(idx);
      end
    end
  end

  assign adv   = en_i & found;
  assign gnt_o = adv ? (REQ_NUM'(1) << gnt_idx_o) : '0;
  assign ptr_d = (gnt_idx_o == ID_W'(REQ_NUM - 1)) ? '0 : gnt_idx_o + 1'b1;

  rvh_pmp_dffre #(.W(ID_W)) u_ptr (
    .clk  (clk),
    .rstn (rstn),
    .en_i (adv),
    .d_i  (ptr_d),
    .q_o  (ptr_q)
  );

endmodule

// File: rtl/rvh_pmp_check_arb.sv
// Arbitrates PMP check requests, broadcasts the winner to the entries, and
// holds the resolved fault in a one-deep response slot.
module rvh_pmp_check_arb
  import rvh_pmp_pkg::*;
#(
  parameter int unsigned PADDR_WIDTH = 56,
  parameter int unsigned REQ_NUM     = 3,
  parameter int unsigned ENTRY_NUM   = 16,
  localparam int unsigned ID_W       = id_width(REQ_NUM)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           flush_i,
  input  logic [REQ_NUM-1:0]             req_vld_i,
  output logic [REQ_NUM-1:0]             req_rdy_o,
  input  logic [REQ_NUM*PADDR_WIDTH-1:0] req_paddr_i,
  input  logic [REQ_NUM*2-1:0]           req_access_type_i,
  input  logic [REQ_NUM-1:0]             req_priv_m_i,
  output logic                           chk_vld_o,
  output logic [PADDR_WIDTH-1:0]         chk_paddr_o,
  output logic [1:0]                     chk_access_type_o,
  input  logic [ENTRY_NUM-1:0]           entry_match_i,
  input  logic [ENTRY_NUM-1:0]           entry_fail_i,
  input  logic [ENTRY_NUM-1:0]           entry_lock_i,
  output logic                           resp_vld_o,
  input  logic                           resp_rdy_i,
  output logic [ID_W-1:0]                resp_id_o,
  output logic                           resp_fault_o
);

  logic                   can_accept;
  logic                   xfer;
  logic [REQ_NUM-1:0]     gnt;
  logic [ID_W-1:0]        gnt_idx;
  logic [PADDR_WIDTH-1:0] sel_paddr;
  logic [1:0]             sel_type;
  logic                   sel_priv_m;
  logic                   hit, hit_fail, hit_lock;
  logic                   fault_d;
  logic                   resp_vld_q, resp_vld_d;
  logic                   resp_fault_q;
  logic [ID_W-1:0]        resp_id_q;

  assign can_accept = ~flush_i & (~resp_vld_q | resp_rdy_i);

  rvh_pmp_rr_arb #(.REQ_NUM(REQ_NUM), .ID_W(ID_W)) u_rr_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req_i     (req_vld_i),
    .en_i      (can_accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_rdy_o  = gnt;
  assign xfer       = |gnt;
  assign sel_paddr  = req_paddr_i[gnt_idx*PADDR_WIDTH +: PADDR_WIDTH];
  assign sel_type   = req_access_type_i[gnt_idx*2 +: 2];
  assign sel_priv_m = req_priv_m_i[gnt_idx];

  assign chk_vld_o         = xfer;
  assign chk_paddr_o       = xfer ? sel_paddr : '0;
  assign chk_access_type_o = xfer ? sel_type : '0;

  // Scanning downward leaves the lowest-index matching entry in hit_*.
  always_comb begin
    hit      = 1'b0;
    hit_fail = 1'b0;
    hit_lock = 1'b0;
    for (int unsigned i = ENTRY_NUM; i > 0; i--) begin
      if (entry_match_i[i-1]) begin
        hit      = 1'b1;
        hit_fail = entry_fail_i[i-1];
        hit_lock = entry_lock_i[i-1];
      end
    end
  end

  always_comb begin
    fault_d = ~sel_priv_m;
    if (sel_type == PMP_ACC_RSVD) begin
      fault_d = 1'b1;
    end else if (hit) begin
      fault_d = hit_fail & (~sel_priv_m | hit_lock);
    end
  end

  always_comb begin
    resp_vld_d = resp_vld_q;
    if (flush_i) begin
      resp_vld_d = 1'b0;
    end else if (xfer) begin
      resp_vld_d = 1'b1;
    end else if (resp_rdy_i) begin
      resp_vld_d = 1'b0;
    end
  end

  rvh_pmp_dffre #(.W(1)) u_resp_vld (
    .clk (clk), .rstn (rstn), .en_i (1'b1), .d_i (resp_vld_d), .q_o (resp_vld_q)
  );

  rvh_pmp_dffre #(.W(ID_W)) u_resp_id (
    .clk (clk), .rstn (rstn), .en_i (xfer), .d_i (gnt_idx), .q_o (resp_id_q)
  );

  rvh_pmp_dffre #(.W(1)) u_resp_fault (
    .clk (clk), .rstn (rstn), .en_i (xfer), .d_i (fault_d), .q_o (resp_fault_q)
  );

  assign resp_vld_o   = resp_vld_q;
  assign resp_id_o    = resp_id_q;
  assign resp_fault_o = resp_fault_q;

endmodule

// File: tb/tb_rvh_pmp_check_arb.sv
// Directed bench for rvh_pmp_check_arb: arbitration order, fault resolution,
// back-pressure, flush and asynchronous reset.
module tb_rvh_pmp_check_arb;

  localparam int unsigned PW = 56;
  localparam int unsigned RN = 3;
  localparam int unsigned EN = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             flush_i;
  logic [RN-1:0]    req_vld_i;
  logic [RN-1:0]    req_rdy_o;
  logic [RN*PW-1:0] req_paddr_i;
  logic [RN*2-1:0]  req_access_type_i;
  logic [RN-1:0]    req_priv_m_i;
  logic             chk_vld_o;
  logic [PW-1:0]    chk_paddr_o;
  logic [1:0]       chk_access_type_o;
  logic [EN-1:0]    entry_match_i;
  logic [EN-1:0]    entry_fail_i;
  logic [EN-1:0]    entry_lock_i;
  logic             resp_vld_o;
  logic             resp_rdy_i;
  logic [1:0]       resp_id_o;
  logic             resp_fault_o;

  int checks   = 0;
  int failures = 0;

  rvh_pmp_check_arb #(.PADDR_WIDTH(PW), .REQ_NUM(RN), .ENTRY_NUM(EN)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .flush_i           (flush_i),
    .req_vld_i         (req_vld_i),
    .req_rdy_o         (req_rdy_o),
    .req_paddr_i       (req_paddr_i),
    .req_access_type_i (req_access_type_i),
    .req_priv_m_i      (req_priv_m_i),
    .chk_vld_o         (chk_vld_o),
    .chk_paddr_o       (chk_paddr_o),
    .chk_access_type_o (chk_access_type_o),
    .entry_match_i     (entry_match_i),
    .entry_fail_i      (entry_fail_i),
    .entry_lock_i      (entry_lock_i),
    .resp_vld_o        (resp_vld_o),
    .resp_rdy_i        (resp_rdy_i),
    .resp_id_o         (resp_id_o),
    .resp_fault_o      (resp_fault_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [PW-1:0] pa, input logic [1:0] ty,
                         input logic pm);
    req_paddr_i[idx*PW +: PW]    = pa;
    req_access_type_i[idx*2 +: 2] = ty;
    req_priv_m_i[idx]             = pm;
  endtask

  // One isolated request from requester idx; response checked next cycle.
  task automatic single(input string tag, input int idx, input logic [PW-1:0] pa,
                        input logic [1:0] ty, input logic pm, input logic [EN-1:0] m,
                        input logic [EN-1:0] f, input logic [EN-1:0] l, input logic exp_fault);
    set_req(idx, pa, ty, pm);
    entry_match_i = m;
    entry_fail_i  = f;
    entry_lock_i  = l;
    req_vld_i     = RN'(1) << idx;
    #1;
    chk({tag, "_rdy"}, 64'(req_rdy_o), 64'(RN'(1) << idx));
    chk({tag, "_chk_vld"}, 64'(chk_vld_o), 64'd1);
    chk({tag, "_chk_paddr"}, 64'(chk_paddr_o), 64'(pa));
    chk({tag, "_chk_type"}, 64'(chk_access_type_o), 64'(ty));
    step();
    req_vld_i = '0;
    chk({tag, "_resp_vld"}, 64'(resp_vld_o), 64'd1);
    chk({tag, "_resp_id"}, 64'(resp_id_o), 64'(idx));
    chk({tag, "_fault"}, 64'(resp_fault_o), 64'(exp_fault));
  endtask

  initial begin
    rstn = 1'b0; flush_i = 1'b0; req_vld_i = '0; req_paddr_i = '0;
    req_access_type_i = '0; req_priv_m_i = '0; entry_match_i = '0;
    entry_fail_i = '0; entry_lock_i = '0; resp_rdy_i = 1'b1;
    #1;
    chk("rst_resp_vld", 64'(resp_vld_o), 64'd0);
    chk("rst_resp_id", 64'(resp_id_o), 64'd0);
    chk("rst_resp_fault", 64'(resp_fault_o), 64'd0);
    step(); step();
    rstn = 1'b1;

    // Three requesters competing, consumer always ready.
    set_req(0, 56'h100, 2'd0, 1'b1);
    set_req(1, 56'h200, 2'd0, 1'b1);
    set_req(2, 56'h300, 2'd0, 1'b1);
    req_vld_i = 3'b111;
    #1;
    chk("rr_g0_rdy", 64'(req_rdy_o), 64'b001);
    chk("rr_g0_paddr", 64'(chk_paddr_o), 64'h100);
    step();
    chk("rr_c1_vld", 64'(resp_vld_o), 64'd1);
    chk("rr_c1_id", 64'(resp_id_o), 64'd0);
    chk("rr_g1_rdy", 64'(req_rdy_o), 64'b010);
    chk("rr_g1_paddr", 64'(chk_paddr_o), 64'h200);
    step();
    chk("rr_c2_id", 64'(resp_id_o), 64'd1);
    chk("rr_g2_rdy", 64'(req_rdy_o), 64'b100);
    step();
    chk("rr_c3_id", 64'(resp_id_o), 64'd2);
    chk("rr_c3_fault", 64'(resp_fault_o), 64'd0);
    req_vld_i = '0;
    #1;
    chk("idle_rdy", 64'(req_rdy_o), 64'd0);
    chk("idle_chk_vld", 64'(chk_vld_o), 64'd0);
    chk("idle_chk_paddr", 64'(chk_paddr_o), 64'd0);
    step();
    chk("idle_resp_vld", 64'(resp_vld_o), 64'd0);

    // Pointer is 0: requester 1 found next, then 2, 0, 1, 2, 0.
    single("low_idx_win", 1, 56'h8000_0000, 2'd1, 1'b0, 16'h0006, 16'h0004, 16'h0000, 1'b0);
    single("m_unlocked", 2, 56'h1234, 2'd0, 1'b1, 16'h0001, 16'h0001, 16'h0000, 1'b0);
    single("m_locked", 0, 56'h1238, 2'd0, 1'b1, 16'h0001, 16'h0001, 16'h0001, 1'b1);
    single("nomatch_m", 1, 56'h4000, 2'd2, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    single("nomatch_u", 2, 56'h4004, 2'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    single("rsvd_type", 0, 56'h4008, 2'd3, 1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b1);
    single("u_fail", 1, 56'h400c, 2'd1, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1);
    entry_match_i = '0; entry_fail_i = '0; entry_lock_i = '0;

    // Back-pressure: pointer is 2 after the last grant to requester 1.
    set_req(0, 56'h10, 2'd0, 1'b1);
    set_req(1, 56'h20, 2'd0, 1'b0);
    set_req(2, 56'h30, 2'd0, 1'b1);
    req_vld_i = 3'b111;
    #1;
    chk("bp_first_rdy", 64'(req_rdy_o), 64'b100);
    step();
    resp_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_hold_rdy", 64'(req_rdy_o), 64'd0);
      chk("bp_hold_chk", 64'(chk_vld_o), 64'd0);
      step();
      chk("bp_hold_vld", 64'(resp_vld_o), 64'd1);
      chk("bp_hold_id", 64'(resp_id_o), 64'd2);
      chk("bp_hold_fault", 64'(resp_fault_o), 64'd0);
    end
    resp_rdy_i = 1'b1;
    #1;
    chk("bp_release_rdy", 64'(req_rdy_o), 64'b001);
    chk("bp_release_paddr", 64'(chk_paddr_o), 64'h10);
    step();
    chk("bp_reload_vld", 64'(resp_vld_o), 64'd1);
    chk("bp_reload_id", 64'(resp_id_o), 64'd0);

    // Flush beats a concurrent consume and leaves the pointer at 1.
    flush_i = 1'b1;
    #1;
    chk("flush_rdy", 64'(req_rdy_o), 64'd0);
    chk("flush_chk", 64'(chk_vld_o), 64'd0);
    step();
    flush_i = 1'b0;
    chk("flush_resp_vld", 64'(resp_vld_o), 64'd0);
    #1;
    chk("post_flush_rdy", 64'(req_rdy_o), 64'b010);
    step();
    chk("post_flush_id", 64'(resp_id_o), 64'd1);
    chk("post_flush_fault", 64'(resp_fault_o), 64'd1);

    // Asynchronous reset in the middle of a held response.
    resp_rdy_i = 1'b0;
    #2;
    rstn      = 1'b0;
    req_vld_i = '0;
    #1;
    chk("arst_resp_vld", 64'(resp_vld_o), 64'd0);
    chk("arst_resp_id", 64'(resp_id_o), 64'd0);
    chk("arst_resp_fault", 64'(resp_fault_o), 64'd0);
    chk("arst_chk_vld", 64'(chk_vld_o), 64'd0);
    chk("arst_rdy", 64'(req_rdy_o), 64'd0);
    step();
    chk("arst_no_pulse", 64'(resp_vld_o), 64'd0);
    rstn       = 1'b1;
    resp_rdy_i = 1'b1;
    req_vld_i  = 3'b110;
    #1;
    chk("arst_ptr_zero_rdy", 64'(req_rdy_o), 64'b010);
    step();
    chk("arst_after_id", 64'(resp_id_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
